// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed little-endian byte image into the
// instruction memory and holds the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WIDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [31:0]         word_q, word_d;
  logic                accept_c;
  logic [CNT_W-1:0]    hdr_n_c;

  // rx_ready is a state decode, so the handshake never depends on rx_valid combinationally
  assign accept_c = rx_valid && rx_ready;
  assign hdr_n_c  = CNT_W'({rx_data, cnt_q[7:0]});

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR0;
      end
      S_HDR0: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(rx_data);
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept_c) begin
          cnt_d = hdr_n_c;
          if (hdr_n_c == CNT_W'(0) || hdr_n_c > CNT_W'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            widx_d  = WIDX_W'(0);
            bidx_d  = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          word_d[{bidx_q, 3'b000} +: 8] = rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (CNT_W'(widx_q) == cnt_q - CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          widx_d  = widx_q + WIDX_W'(1);
          bidx_d  = 2'd0;
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
    end
  end

  // Registered outputs, decoded from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      core_rst <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      rx_ready <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
      busy     <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                  (state_d == S_DATA) || (state_d == S_WRITE);
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERR);
      core_rst <= (state_d == S_DONE);
      mem_we   <= (state_d == S_WRITE);
      // Address/data capture only on entry to WRITE and hold otherwise
      if (state_q == S_DATA && state_d == S_WRITE) begin
        mem_addr <= 32'({widx_q, 2'b00});
        mem_wd   <= word_d;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized image loads checked
// against an image-level expectation (address i*4 holds word i).
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int ready_viol = 0;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_words[$];

  imem_boot_loader #(.DEPTH(1024), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every memory write as seen by the memory
  always @(negedge clk) begin
    if (rst && mem_we) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wd);
      if (rx_ready) ready_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wd"}, mem_wd, 0);
    check({tag, "_core_rst"}, core_rst, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cap_addr.delete();
    cap_data.delete();
    ready_viol = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte (after an optional random gap) until accepted; returns at edge+1
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    bit acc;
    acc = 1'b0;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = $urandom;
    check("rx_accept", acc, 1);
  endtask

  // Full load: start, header n, and exp_words as payload when n is legal
  task automatic run_load(input string tag, input int n, input int max_gap,
                          input bit noise, input bit collide);
    logic [15:0] n16;
    bit legal;
    int bad;
    n16 = 16'(n);
    legal = (n >= 1) && (n <= 1024);
    start = 1'b1;
    if (collide) begin
      rx_valid = 1'b1;
      rx_data = 8'hA5;
    end
    @(posedge clk);
    #1 start = 1'b0;
    rx_valid = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    send_byte(n16[7:0], max_gap);
    send_byte(n16[15:8], max_gap);
    if (!legal) begin
      check({tag, "_error"}, error, 1);
      check({tag, "_core_rst"}, core_rst, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rx_ready"}, rx_ready, 0);
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      pulse_start();
      check({tag, "_error_sticky"}, error, 1);
      check({tag, "_busy_ignored_start"}, busy, 0);
      check({tag, "_rx_ready_ignored_start"}, rx_ready, 0);
      check({tag, "_no_writes"}, cap_addr.size(), 0);
      check({tag, "_done"}, done, 0);
      return;
    end
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (noise && w == 0 && b == 2) begin
          pulse_start();
          check({tag, "_busy_noise"}, busy, 1);
          check({tag, "_rx_ready_noise"}, rx_ready, 1);
        end
        send_byte(8'(exp_words[w] >> (8 * b)), max_gap);
      end
      check({tag, "_we"}, mem_we, 1);
      check({tag, "_we_rx_ready"}, rx_ready, 0);
      check({tag, "_addr"}, mem_addr, 32'(w * 4));
      check({tag, "_wd"}, mem_wd, exp_words[w]);
      check({tag, "_done_early"}, done, 0);
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_we_end"}, mem_we, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_write_count"}, cap_addr.size(), n);
    bad = 0;
    for (int i = 0; i < cap_addr.size() && i < n; i++) begin
      if (cap_addr[i] !== 32'(i * 4) || cap_data[i] !== exp_words[i]) bad++;
    end
    check({tag, "_write_contents"}, bad, 0);
    check({tag, "_ready_in_write"}, ready_viol, 0);
    if (noise) begin
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_sticky"}, done, 1);
      check({tag, "_busy_after_done_start"}, busy, 0);
      check({tag, "_no_extra_writes"}, cap_addr.size(), n);
    end
  endtask

  initial begin
    #3;
    check_reset_outputs("por");
    do_reset();
    check_reset_outputs("post_reset");

    // single word, with a byte colliding with start in IDLE
    exp_words = '{32'h00000513};
    run_load("single", 1, 0, 1'b0, 1'b1);

    // three words with random valid gaps
    do_reset();
    exp_words = '{32'h00500093, 32'h00100113, 32'h002081B3};
    run_load("multi", 3, 3, 1'b0, 1'b0);

    // illegal headers
    do_reset();
    run_load("n0", 0, 0, 1'b0, 1'b0);
    do_reset();
    run_load("n1025", 1025, 1, 1'b0, 1'b0);
    do_reset();
    run_load("nffff", 65535, 0, 1'b0, 1'b0);

    // reset in the middle of the second word
    do_reset();
    exp_words = '{$urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 4; b++) send_byte(8'(exp_words[0] >> (8 * b)), 1);
    for (int b = 0; b < 2; b++) send_byte(8'(exp_words[1] >> (8 * b)), 1);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midload_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midload_idle_busy", busy, 0);
    check("midload_write_count", cap_addr.size(), 1);
    check("midload_first_addr", cap_addr[0], 0);
    check("midload_first_data", cap_data[0], exp_words[0]);
    cap_addr.delete();
    cap_data.delete();
    ready_viol = 0;
    exp_words = '{32'hDEADBEEF};
    run_load("reload", 1, 0, 1'b0, 1'b0);

    // spurious start pulses during DATA and in DONE
    do_reset();
    exp_words.delete();
    for (int i = 0; i < 4; i++) exp_words.push_back($urandom);
    run_load("noise", 4, 2, 1'b1, 1'b0);

    // randomized legal loads
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      n = int'($urandom_range(12, 1));
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      run_load("rand", n, int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom));
    end

    // largest legal image
    do_reset();
    exp_words.delete();
    for (int i = 0; i < 1024; i++) exp_words.push_back($urandom);
    run_load("full", 1024, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
